// File: rtl/tl_router_pkg.sv
// Shared TileLink-UL definitions: opcodes, channel structs, router states
// and the address region decode used by the router and the devices behind it.
package tl_router_pkg;

  localparam logic [2:0] OP_GET              = 3'd4;
  localparam logic [2:0] OP_PUT_FULL_DATA    = 3'd0;
  localparam logic [2:0] OP_PUT_PARTIAL_DATA = 3'd1;
  localparam logic [2:0] OP_ACCESS_ACK       = 3'd0;
  localparam logic [2:0] OP_ACCESS_ACK_DATA  = 3'd1;

  // A channel. a_ready travels in the opposite direction of the payload:
  // it is the D-channel ready of whoever receives this struct's responses.
  typedef struct packed {
    logic        a_valid;
    logic [2:0]  a_opcode;
    logic [2:0]  a_param;
    logic [2:0]  a_size;
    logic [7:0]  a_source;
    logic [31:0] a_address;
    logic [3:0]  a_mask;
    logic [31:0] a_data;
    logic        a_ready;
  } tilelink_a;

  // D channel. d_ready is the A-channel ready of the sender of this struct.
  typedef struct packed {
    logic        d_valid;
    logic [2:0]  d_opcode;
    logic [1:0]  d_param;
    logic [2:0]  d_size;
    logic [7:0]  d_source;
    logic        d_sink;
    logic [31:0] d_data;
    logic        d_error;
    logic        d_ready;
  } tilelink_d;

  // Payload-only copies held in the router's request/response registers.
  typedef struct packed {
    logic [2:0]  opcode;
    logic [2:0]  param;
    logic [2:0]  size;
    logic [7:0]  source;
    logic [31:0] address;
    logic [3:0]  mask;
    logic [31:0] data;
  } a_fields_t;

  typedef struct packed {
    logic [2:0]  opcode;
    logic [1:0]  param;
    logic [2:0]  size;
    logic [7:0]  source;
    logic        sink;
    logic [31:0] data;
    logic        error;
  } d_fields_t;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} router_state_e;

  // Region is the top nibble of the address.
  function automatic logic region_hit(input logic [31:0] addr, input logic [3:0] region);
    return (addr >> 28) == {28'd0, region};
  endfunction

  function automatic logic opcode_legal(input logic [2:0] opcode);
    return (opcode == OP_GET) || (opcode == OP_PUT_FULL_DATA) || (opcode == OP_PUT_PARTIAL_DATA);
  endfunction

  // Local error responses carry AccessAckData only for Get.
  function automatic logic [2:0] ack_opcode(input logic [2:0] req_opcode);
    return (req_opcode == OP_GET) ? OP_ACCESS_ACK_DATA : OP_ACCESS_ACK;
  endfunction

endpackage

// File: rtl/tl_router.sv
// Single-host to two-device TL-UL router with one outstanding transaction.
// Unmapped addresses, illegal opcodes and silent devices are answered locally
// with d_error=1.
//
// state | meaning
// IDLE  | ready for a host request (host_tld.d_ready=1)
// ISSUE | request presented to the selected device until it is accepted
// WAIT  | waiting for the selected device's response, timeout counter running
// RESP  | response held to the host until host_tla.a_ready
module tl_router
  import tl_router_pkg::*;
#(
  parameter logic [3:0] DEV0_REGION = 4'h5,
  parameter logic [3:0] DEV1_REGION = 4'h8,
  parameter int         TIMEOUT     = 16   // must be >= 2
) (
  input  logic      clock,
  input  logic      reset_n,
  input  tilelink_a host_tla,
  output tilelink_d host_tld,
  output tilelink_a dev0_tla,
  input  tilelink_d dev0_tld,
  output tilelink_a dev1_tla,
  input  tilelink_d dev1_tld
);

  localparam int               CNT_W    = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  router_state_e    state, state_next;
  logic             sel, sel_next;      // 0 = device 0, 1 = device 1
  a_fields_t        req, req_next;
  d_fields_t        rsp, rsp_next;
  logic [CNT_W-1:0] cnt, cnt_next;
  tilelink_d        dev_rsp;

  // Next-state logic: capture, decode, device handshake, timeout and host handshake.
  always_comb begin
    state_next = state;
    sel_next   = sel;
    req_next   = req;
    rsp_next   = rsp;
    cnt_next   = cnt;
    dev_rsp    = sel ? dev1_tld : dev0_tld;

    unique case (state)
      IDLE: begin
        if (host_tla.a_valid) begin
          req_next = '{opcode:  host_tla.a_opcode,
                       param:   host_tla.a_param,
                       size:    host_tla.a_size,
                       source:  host_tla.a_source,
                       address: host_tla.a_address,
                       mask:    host_tla.a_mask,
                       data:    host_tla.a_data};
          // Preload the local error response; overwritten if a device answers.
          rsp_next        = '0;
          rsp_next.size   = host_tla.a_size;
          rsp_next.source = host_tla.a_source;
          rsp_next.error  = 1'b1;
          rsp_next.opcode = ack_opcode(host_tla.a_opcode);
          if (!opcode_legal(host_tla.a_opcode)) begin
            rsp_next.opcode = OP_ACCESS_ACK;
            state_next      = RESP;
          end else if (region_hit(host_tla.a_address, DEV0_REGION)) begin
            sel_next   = 1'b0;
            state_next = ISSUE;
          end else if (region_hit(host_tla.a_address, DEV1_REGION)) begin
            sel_next   = 1'b1;
            state_next = ISSUE;
          end else begin
            state_next = RESP;
          end
        end
      end
      ISSUE: begin
        if (dev_rsp.d_ready) begin
          cnt_next   = '0;
          state_next = WAIT;
        end
      end
      WAIT: begin
        // A response on the timeout cycle still wins.
        if (dev_rsp.d_valid) begin
          rsp_next = '{opcode: dev_rsp.d_opcode,
                       param:  dev_rsp.d_param,
                       size:   dev_rsp.d_size,
                       source: dev_rsp.d_source,
                       sink:   dev_rsp.d_sink,
                       data:   dev_rsp.d_data,
                       error:  dev_rsp.d_error};
          state_next = RESP;
        end else if (cnt == CNT_LAST) begin
          rsp_next        = '0;
          rsp_next.opcode = ack_opcode(req.opcode);
          rsp_next.size   = req.size;
          rsp_next.source = req.source;
          rsp_next.error  = 1'b1;
          state_next      = RESP;
        end else if (cnt != CNT_MAX) begin
          cnt_next = cnt + CNT_W'(1);
        end
      end
      RESP: begin
        if (host_tla.a_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // State and datapath registers; reset aborts any transaction in flight.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state <= IDLE;
      sel   <= 1'b0;
      req   <= '0;
      rsp   <= '0;
      cnt   <= '0;
    end else begin
      state <= state_next;
      sel   <= sel_next;
      req   <= req_next;
      rsp   <= rsp_next;
      cnt   <= cnt_next;
    end
  end

  // Outputs come straight from registers; valids/readies are decoded from state.
  always_comb begin
    host_tld = '{d_valid:  state == RESP,
                 d_opcode: rsp.opcode,
                 d_param:  rsp.param,
                 d_size:   rsp.size,
                 d_source: rsp.source,
                 d_sink:   rsp.sink,
                 d_data:   rsp.data,
                 d_error:  rsp.error,
                 d_ready:  state == IDLE};
    dev0_tla = '{a_valid:   (state == ISSUE) && !sel,
                 a_opcode:  req.opcode,
                 a_param:   req.param,
                 a_size:    req.size,
                 a_source:  req.source,
                 a_address: req.address,
                 a_mask:    req.mask,
                 a_data:    req.data,
                 a_ready:   (state == WAIT) && !sel};
    dev1_tla = '{a_valid:   (state == ISSUE) && sel,
                 a_opcode:  req.opcode,
                 a_param:   req.param,
                 a_size:    req.size,
                 a_source:  req.source,
                 a_address: req.address,
                 a_mask:    req.mask,
                 a_data:    req.data,
                 a_ready:   (state == WAIT) && sel};
  end

endmodule

// File: tb/tb_tl_router.sv
// Self-checking bench for tl_router: expected host responses are queued when a
// request is driven and compared when host_tld.d_valid appears.
module tb_tl_router;
  import tl_router_pkg::tilelink_a;
  import tl_router_pkg::tilelink_d;

  localparam logic [2:0] GET   = 3'd4;
  localparam logic [2:0] PUTF  = 3'd0;
  localparam logic [2:0] PUTP  = 3'd1;
  localparam logic [2:0] ACK   = 3'd0;
  localparam logic [2:0] ACKD  = 3'd1;

  typedef struct {
    logic [2:0]  opcode;
    logic [31:0] data;
    logic        error;
    logic [7:0]  source;
    logic [2:0]  size;
  } exp_t;

  logic      clock = 1'b0;
  logic      reset_n;
  tilelink_a host_tla, dev0_tla, dev1_tla;
  tilelink_d host_tld, dev0_tld, dev1_tld;

  int errors = 0;
  int checks = 0;
  exp_t sb[$];
  logic [31:0] ref_mem [logic [31:0]];
  logic [31:0] dev_mem [logic [31:0]];

  tl_router #(.DEV0_REGION(4'h5), .DEV1_REGION(4'h8), .TIMEOUT(16)) dut (
    .clock(clock), .reset_n(reset_n),
    .host_tla(host_tla), .host_tld(host_tld),
    .dev0_tla(dev0_tla), .dev0_tld(dev0_tld),
    .dev1_tla(dev1_tla), .dev1_tld(dev1_tld)
  );

  always #5 clock = ~clock;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw, input logic [3:0] mask);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (mask[b]) r[8*b +: 8] = nw[8*b +: 8];
    return r;
  endfunction

  function automatic tilelink_a dev_a(input int d);
    return (d == 1) ? dev1_tla : dev0_tla;
  endfunction

  task automatic set_dev_ready(input int d, input logic v);
    if (d == 1) dev1_tld.d_ready = v; else dev0_tld.d_ready = v;
  endtask

  task automatic set_dev_resp(input int d, input logic v, input logic [2:0] op,
                              input logic [31:0] data, input logic [7:0] src, input logic err);
    tilelink_d t;
    t = (d == 1) ? dev1_tld : dev0_tld;
    t.d_valid = v; t.d_opcode = op; t.d_param = 2'd0; t.d_size = 3'd2;
    t.d_source = src; t.d_sink = 1'b1; t.d_data = data; t.d_error = err;
    if (d == 1) dev1_tld = t; else dev0_tld = t;
  endtask

  task automatic drive_req(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] data,
                           input logic [3:0] mask, input logic [7:0] src);
    host_tla.a_valid = 1'b1; host_tla.a_opcode = op; host_tla.a_param = 3'd0;
    host_tla.a_size = 3'd2; host_tla.a_source = src; host_tla.a_address = addr;
    host_tla.a_mask = mask; host_tla.a_data = data;
  endtask

  // One complete host transaction with configurable device/host stalls.
  task automatic host_txn(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] data,
                          input logic [3:0] mask, input logic [7:0] src, input int dready_wait,
                          input bit silent, input int aready_wait, input string name);
    exp_t e, got;
    bit legal, mapped;
    int dev, n;
    tilelink_a a;
    legal  = (op == GET) || (op == PUTF) || (op == PUTP);
    dev    = (addr[31:28] == 4'h5) ? 0 : (addr[31:28] == 4'h8) ? 1 : -1;
    mapped = legal && (dev >= 0);
    e.source = src; e.size = 3'd2;
    if (!legal) begin
      e.opcode = ACK; e.data = 32'h0; e.error = 1'b1;
    end else if (!mapped || silent) begin
      e.opcode = (op == GET) ? ACKD : ACK; e.data = 32'h0; e.error = 1'b1;
    end else if (op == GET) begin
      e.opcode = ACKD; e.data = ref_mem.exists(addr) ? ref_mem[addr] : 32'h0; e.error = 1'b0;
    end else begin
      e.opcode = ACK; e.data = 32'h0; e.error = 1'b0;
      ref_mem[addr] = merge(ref_mem.exists(addr) ? ref_mem[addr] : 32'h0, data, mask);
    end
    sb.push_back(e);

    drive_req(op, addr, data, mask, src);
    checks++;
    if (host_tld.d_ready !== 1'b1)
      begin errors++; $display("FAIL %s accept_ready: got %b want 1", name, host_tld.d_ready); end
    @(negedge clock);
    host_tla.a_valid = 1'b0;

    if (mapped) begin
      for (int i = 0; i <= dready_wait; i++) begin
        a = dev_a(dev);
        checks++;
        if (a.a_valid !== 1'b1 || a.a_address !== addr || a.a_data !== data || a.a_mask !== mask ||
            a.a_opcode !== op || a.a_source !== src || a.a_size !== 3'd2)
          begin errors++; $display("FAIL %s issue_fields cyc%0d: got v=%b addr=%h data=%h mask=%b op=%0d src=%h want v=1 addr=%h data=%h mask=%b op=%0d src=%h",
                                   name, i, a.a_valid, a.a_address, a.a_data, a.a_mask, a.a_opcode, a.a_source, addr, data, mask, op, src); end
        checks++;
        if (dev_a(1 - dev).a_valid !== 1'b0 || host_tld.d_ready !== 1'b0)
          begin errors++; $display("FAIL %s issue_other: got other_valid=%b host_ready=%b want 0 0",
                                   name, dev_a(1 - dev).a_valid, host_tld.d_ready); end
        if (i == dready_wait) begin
          set_dev_ready(dev, 1'b1);
          if (op != GET) dev_mem[a.a_address] = merge(dev_mem.exists(a.a_address) ? dev_mem[a.a_address] : 32'h0, a.a_data, a.a_mask);
        end
        @(negedge clock);
      end
      set_dev_ready(dev, 1'b0);
      a = dev_a(dev);
      checks++;
      if (a.a_valid !== 1'b0 || a.a_ready !== 1'b1)
        begin errors++; $display("FAIL %s wait_entry: got a_valid=%b a_ready=%b want 0 1", name, a.a_valid, a.a_ready); end
      if (!silent) begin
        set_dev_resp(dev, 1'b1, (op == GET) ? ACKD : ACK,
                     (op == GET) ? (dev_mem.exists(addr) ? dev_mem[addr] : 32'h0) : 32'h0, src, 1'b0);
        @(negedge clock);
        set_dev_resp(dev, 1'b0, ACK, 32'h0, 8'h0, 1'b0);
      end else begin
        n = 0;
        while (host_tld.d_valid !== 1'b1 && n < 40) begin @(negedge clock); n++; end
        checks++;
        if (n != 16) begin errors++; $display("FAIL %s timeout_cycles: got %0d want 16", name, n); end
      end
    end else begin
      checks++;
      if (dev0_tla.a_valid !== 1'b0 || dev1_tla.a_valid !== 1'b0)
        begin errors++; $display("FAIL %s no_dev_issue: got dev0=%b dev1=%b want 0 0", name, dev0_tla.a_valid, dev1_tla.a_valid); end
    end

    checks++;
    if (host_tld.d_valid !== 1'b1)
      begin errors++; $display("FAIL %s resp_latency: got d_valid=%b want 1", name, host_tld.d_valid); end
    if (host_tld.d_valid === 1'b1 && sb.size() > 0) begin
      got = sb.pop_front();
      checks++;
      if (host_tld.d_opcode !== got.opcode || host_tld.d_data !== got.data || host_tld.d_error !== got.error ||
          host_tld.d_source !== got.source || host_tld.d_size !== got.size)
        begin errors++; $display("FAIL %s resp_fields: got op=%0d data=%h err=%b src=%h size=%0d want op=%0d data=%h err=%b src=%h size=%0d",
                                 name, host_tld.d_opcode, host_tld.d_data, host_tld.d_error, host_tld.d_source, host_tld.d_size,
                                 got.opcode, got.data, got.error, got.source, got.size); end
    end
    for (int i = 0; i < aready_wait; i++) begin
      @(negedge clock);
      checks++;
      if (host_tld.d_valid !== 1'b1 || host_tld.d_data !== e.data || host_tld.d_error !== e.error ||
          host_tld.d_opcode !== e.opcode || host_tld.d_ready !== 1'b0)
        begin errors++; $display("FAIL %s resp_stable cyc%0d: got v=%b data=%h err=%b op=%0d rdy=%b want 1 %h %b %0d 0",
                                 name, i, host_tld.d_valid, host_tld.d_data, host_tld.d_error, host_tld.d_opcode,
                                 host_tld.d_ready, e.data, e.error, e.opcode); end
    end
    host_tla.a_ready = 1'b1;
    @(negedge clock);
    host_tla.a_ready = 1'b0;
    checks++;
    if (host_tld.d_valid !== 1'b0 || host_tld.d_ready !== 1'b1)
      begin errors++; $display("FAIL %s resp_done: got d_valid=%b d_ready=%b want 0 1", name, host_tld.d_valid, host_tld.d_ready); end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    drive_req(GET, 32'h5000_0000, 32'h0, 4'hF, 8'h01);
    repeat (3) @(negedge clock);
    host_tla.a_valid = 1'b0;
    checks++;
    if (host_tld.d_valid !== 1'b0 || host_tld.d_ready !== 1'b1 || host_tld.d_data !== 32'h0 ||
        host_tld.d_error !== 1'b0 || host_tld.d_opcode !== 3'd0)
      begin errors++; $display("FAIL reset_host: got v=%b rdy=%b data=%h err=%b op=%0d want 0 1 0 0 0",
                               host_tld.d_valid, host_tld.d_ready, host_tld.d_data, host_tld.d_error, host_tld.d_opcode); end
    checks++;
    if (dev0_tla.a_valid !== 1'b0 || dev1_tla.a_valid !== 1'b0 || dev0_tla.a_ready !== 1'b0 ||
        dev1_tla.a_ready !== 1'b0 || dev0_tla.a_address !== 32'h0 || dev1_tla.a_data !== 32'h0)
      begin errors++; $display("FAIL reset_dev: got v0=%b v1=%b r0=%b r1=%b addr=%h data=%h want all 0",
                               dev0_tla.a_valid, dev1_tla.a_valid, dev0_tla.a_ready, dev1_tla.a_ready,
                               dev0_tla.a_address, dev1_tla.a_data); end
    reset_n = 1'b1;
    @(negedge clock);
  endtask

  task automatic test_put_get_dev0();
    host_txn(PUTF, 32'h5000_0000, 32'hDEAD_BEEF, 4'b1111, 8'h11, 0, 1'b0, 0, "put_dev0");
    host_txn(GET,  32'h5000_0000, 32'h0,        4'b1111, 8'h22, 0, 1'b0, 0, "get_dev0");
  endtask

  task automatic test_unmapped();
    host_txn(GET,  32'h3000_0010, 32'h0,        4'hF, 8'h33, 0, 1'b0, 0, "get_unmapped");
    host_txn(3'd2, 32'h5000_0000, 32'h1234_5678, 4'hF, 8'h44, 0, 1'b0, 0, "illegal_op");
    host_txn(PUTF, 32'h9000_0000, 32'hCAFE_F00D, 4'hF, 8'h45, 0, 1'b0, 0, "put_unmapped");
  endtask

  task automatic test_timeout();
    host_txn(GET, 32'h8000_0004, 32'h0, 4'hF, 8'h55, 0, 1'b1, 0, "timeout_dev1");
    set_dev_resp(1, 1'b1, ACKD, 32'hBADB_AD00, 8'h55, 1'b0);
    @(negedge clock);
    set_dev_resp(1, 1'b0, ACK, 32'h0, 8'h0, 1'b0);
    checks++;
    if (host_tld.d_valid !== 1'b0 || host_tld.d_ready !== 1'b1)
      begin errors++; $display("FAIL late_resp_dropped: got d_valid=%b d_ready=%b want 0 1", host_tld.d_valid, host_tld.d_ready); end
    host_txn(PUTF, 32'h8000_0004, 32'h1234_5678, 4'hF, 8'h66, 0, 1'b0, 0, "put_dev1");
    host_txn(GET,  32'h8000_0004, 32'h0,        4'hF, 8'h67, 0, 1'b0, 0, "get_dev1");
  endtask

  task automatic test_backpressure();
    host_txn(PUTP, 32'h5000_0008, 32'hA5A5_A5A5, 4'b0011, 8'h77, 5, 1'b0, 3, "stall_put");
    host_txn(GET,  32'h5000_0008, 32'h0,        4'hF,    8'h78, 0, 1'b0, 2, "stall_get");
  endtask

  task automatic test_back_to_back();
    exp_t e1, e2, got;
    e1 = '{opcode: ACKD, data: ref_mem[32'h5000_0000], error: 1'b0, source: 8'h81, size: 3'd2};
    sb.push_back(e1);
    drive_req(GET, 32'h5000_0000, 32'h0, 4'hF, 8'h81);
    @(negedge clock);
    checks++;
    if (dev0_tla.a_valid !== 1'b1 || host_tld.d_ready !== 1'b0)
      begin errors++; $display("FAIL b2b_issue: got a_valid=%b d_ready=%b want 1 0", dev0_tla.a_valid, host_tld.d_ready); end
    set_dev_ready(0, 1'b1);
    @(negedge clock);
    set_dev_ready(0, 1'b0);
    set_dev_resp(1, 1'b1, ACKD, 32'hBAD0_0BAD, 8'h81, 1'b1);
    @(negedge clock);
    set_dev_resp(1, 1'b0, ACK, 32'h0, 8'h0, 1'b0);
    checks++;
    if (host_tld.d_valid !== 1'b0 || dev0_tla.a_ready !== 1'b1 || host_tld.d_ready !== 1'b0)
      begin errors++; $display("FAIL b2b_ignore_dev1: got d_valid=%b dev0_a_ready=%b d_ready=%b want 0 1 0",
                               host_tld.d_valid, dev0_tla.a_ready, host_tld.d_ready); end
    set_dev_resp(0, 1'b1, ACKD, dev_mem[32'h5000_0000], 8'h81, 1'b0);
    @(negedge clock);
    set_dev_resp(0, 1'b0, ACK, 32'h0, 8'h0, 1'b0);
    checks++;
    if (host_tld.d_valid !== 1'b1 || sb.size() == 0)
      begin errors++; $display("FAIL b2b_first_valid: got d_valid=%b queued=%0d want 1 1", host_tld.d_valid, sb.size()); end
    else begin
      got = sb.pop_front();
      checks++;
      if (host_tld.d_data !== got.data || host_tld.d_error !== got.error || host_tld.d_source !== got.source || host_tld.d_opcode !== got.opcode)
        begin errors++; $display("FAIL b2b_first_fields: got data=%h err=%b src=%h op=%0d want %h %b %h %0d",
                                 host_tld.d_data, host_tld.d_error, host_tld.d_source, host_tld.d_opcode,
                                 got.data, got.error, got.source, got.opcode); end
    end
    e2 = '{opcode: ACKD, data: 32'h0, error: 1'b1, source: 8'h82, size: 3'd2};
    sb.push_back(e2);
    drive_req(GET, 32'h3000_0000, 32'h0, 4'hF, 8'h82);
    host_tla.a_ready = 1'b1;
    @(negedge clock);
    host_tla.a_ready = 1'b0;
    checks++;
    if (host_tld.d_valid !== 1'b0 || host_tld.d_ready !== 1'b1)
      begin errors++; $display("FAIL b2b_idle_gap: got d_valid=%b d_ready=%b want 0 1", host_tld.d_valid, host_tld.d_ready); end
    @(negedge clock);
    host_tla.a_valid = 1'b0;
    checks++;
    if (host_tld.d_valid !== 1'b1 || sb.size() == 0)
      begin errors++; $display("FAIL b2b_second_valid: got d_valid=%b queued=%0d want 1 1", host_tld.d_valid, sb.size()); end
    else begin
      got = sb.pop_front();
      checks++;
      if (host_tld.d_data !== got.data || host_tld.d_error !== got.error || host_tld.d_source !== got.source || host_tld.d_opcode !== got.opcode)
        begin errors++; $display("FAIL b2b_second_fields: got data=%h err=%b src=%h op=%0d want %h %b %h %0d",
                                 host_tld.d_data, host_tld.d_error, host_tld.d_source, host_tld.d_opcode,
                                 got.data, got.error, got.source, got.opcode); end
    end
    host_tla.a_ready = 1'b1;
    @(negedge clock);
    host_tla.a_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    drive_req(GET, 32'h5000_0000, 32'h0, 4'hF, 8'h91);
    @(negedge clock);
    host_tla.a_valid = 1'b0;
    set_dev_ready(0, 1'b1);
    @(negedge clock);
    set_dev_ready(0, 1'b0);
    checks++;
    if (dev0_tla.a_ready !== 1'b1)
      begin errors++; $display("FAIL rstmid_in_wait: got dev0 a_ready=%b want 1", dev0_tla.a_ready); end
    reset_n = 1'b0;
    @(negedge clock);
    checks++;
    if (host_tld.d_valid !== 1'b0 || dev0_tla.a_valid !== 1'b0 || dev0_tla.a_ready !== 1'b0 || host_tld.d_ready !== 1'b1)
      begin errors++; $display("FAIL rstmid_abort: got d_valid=%b a_valid=%b a_ready=%b d_ready=%b want 0 0 0 1",
                               host_tld.d_valid, dev0_tla.a_valid, dev0_tla.a_ready, host_tld.d_ready); end
    reset_n = 1'b1;
    set_dev_resp(0, 1'b1, ACKD, 32'h0BAD_0BAD, 8'h91, 1'b0);
    @(negedge clock);
    set_dev_resp(0, 1'b0, ACK, 32'h0, 8'h0, 1'b0);
    checks++;
    if (host_tld.d_valid !== 1'b0)
      begin errors++; $display("FAIL rstmid_no_resp: got d_valid=%b want 0", host_tld.d_valid); end
    host_txn(GET, 32'h5000_0000, 32'h0, 4'hF, 8'h92, 0, 1'b0, 0, "get_after_reset");
  endtask

  initial begin
    host_tla = '0;
    dev0_tld = '0;
    dev1_tld = '0;
    reset_n  = 1'b0;
    @(negedge clock);
    test_reset();
    test_put_get_dev0();
    test_unmapped();
    test_timeout();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    checks++;
    if (sb.size() != 0)
      begin errors++; $display("FAIL scoreboard_drain: got %0d pending want 0", sb.size()); end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
